// File: rtl/mldsa_params_pkg.sv
// Shared ML-DSA parameters and the power2round stream FSM state type.
// Contents: modulus, dropped-bit count, coefficient and output field widths,
// polynomial length, and the p2r_state_e state encoding.
package mldsa_params_pkg;

    localparam int          REG_SIZE    = 23;
    localparam logic [22:0] MLDSA_Q     = 23'd8380417;  // inputs must already be < q
    localparam int          MLDSA_D     = 13;
    localparam int          T1_WIDTH    = 10;
    localparam int          T0_WIDTH    = 13;
    localparam int          POLY_COEFFS = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } p2r_state_e;

endpackage

// File: rtl/power2round_core.sv
// Combinational power2round split of one coefficient r < q.
// Ports:
//   r   in  REG_SIZE  coefficient
//   r1  out T1_WIDTH  high part, (r + 2^(d-1) - 1) >> d
//   r0  out MLDSA_D   low part r - r1*2^d, two's complement in [-4095, 4096]
module power2round_core
    import mldsa_params_pkg::*;
(
    input  logic [REG_SIZE-1:0] r,
    output logic [T1_WIDTH-1:0] r1,
    output logic [MLDSA_D-1:0]  r0
);

    localparam logic [REG_SIZE-1:0] ROUND = REG_SIZE'((1 << (MLDSA_D - 1)) - 1);

    // r + 4095 stays below 2^23 for every r < q, so no carry is lost.
    assign r1 = T1_WIDTH'((r + ROUND) >> MLDSA_D);
    // Only the low d bits survive; r0 = 4096 wraps to 13'h1000, which the
    // t0 encoding treats correctly modulo 2^13.
    assign r0 = MLDSA_D'(r - {r1, {MLDSA_D{1'b0}}});

endmodule

// File: rtl/power2round_pack_stream.sv
// Streaming power2round for ML-DSA KeyGen: takes t coefficients four per
// beat, emits packed t1 (10 bit) and encoded t0 ((2^12 - r0) mod 2^13) beats.
// Ports:
//   clk, reset (async, active high), zeroize (sync clear)
//   start              begins a run from IDLE
//   in_valid/in_ready  input handshake, in_data coefficient i at [24i+22:24i]
//   out_valid/out_ready output handshake
//   t1_data, t0_data   packed per-coefficient results
//   out_last, out_poly last beat of polynomial / polynomial index
//   busy               RUN or FLUSH
//   done               one-cycle pulse after the final output handshake
module power2round_pack_stream
    import mldsa_params_pkg::*;
#(
    parameter int COEFF_PER_BEAT = 4,
    parameter int NUM_POLY       = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               zeroize,
    input  logic                               start,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [COEFF_PER_BEAT*24-1:0]       in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [COEFF_PER_BEAT*T1_WIDTH-1:0] t1_data,
    output logic [COEFF_PER_BEAT*T0_WIDTH-1:0] t0_data,
    output logic                               out_last,
    output logic [$clog2(NUM_POLY)-1:0]        out_poly,
    output logic                               busy,
    output logic                               done
);

    localparam int                PW        = $clog2(NUM_POLY);
    localparam logic [5:0]        LAST_BEAT = 6'(POLY_COEFFS / COEFF_PER_BEAT - 1);
    localparam logic [PW-1:0]     LAST_POLY = PW'(NUM_POLY - 1);
    localparam logic [T0_WIDTH-1:0] T0_BIAS = T0_WIDTH'(1 << (MLDSA_D - 1));

    p2r_state_e    state, state_next;
    logic [5:0]    beat_cnt;
    logic [PW-1:0] poly_cnt;
    logic          accept;
    logic          beat_wrap;
    logic          final_beat;

    logic [COEFF_PER_BEAT*T1_WIDTH-1:0] t1_next;
    logic [COEFF_PER_BEAT*T0_WIDTH-1:0] t0_next;
    logic [COEFF_PER_BEAT-1:0]          pad_unused;

    // Single output register with full throughput: refill in the same cycle
    // the downstream drains it.
    assign in_ready   = (state == RUN) & (!out_valid | out_ready);
    assign accept     = in_valid & in_ready;
    assign beat_wrap  = (beat_cnt == LAST_BEAT);
    assign final_beat = accept & beat_wrap & (poly_cnt == LAST_POLY);

    for (genvar i = 0; i < COEFF_PER_BEAT; i++) begin : g_lane
        logic [T1_WIDTH-1:0] r1;
        logic [MLDSA_D-1:0]  r0;

        power2round_core u_core (
            .r  (in_data[24*i +: REG_SIZE]),
            .r1 (r1),
            .r0 (r0)
        );

        assign t1_next[T1_WIDTH*i +: T1_WIDTH] = r1;
        assign t0_next[T0_WIDTH*i +: T0_WIDTH] = T0_BIAS - r0;
        assign pad_unused[i] = in_data[24*i + 23];  // padding bit, ignored
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:  if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (final_beat) state_next = FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                if (!out_valid | out_ready) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        state <= IDLE;
        else if (zeroize) state <= IDLE;
        else              state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
            poly_cnt <= '0;
        end else if (zeroize || (state == IDLE && start)) begin
            beat_cnt <= '0;
            poly_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= beat_wrap ? 6'd0 : beat_cnt + 6'd1;
            if (beat_wrap)
                poly_cnt <= (poly_cnt == LAST_POLY) ? '0 : poly_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            t1_data   <= '0;
            t0_data   <= '0;
            out_last  <= 1'b0;
            out_poly  <= '0;
        end else if (zeroize) begin
            out_valid <= 1'b0;
            t1_data   <= '0;
            t0_data   <= '0;
            out_last  <= 1'b0;
            out_poly  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            t1_data   <= t1_next;
            t0_data   <= t0_next;
            out_last  <= beat_wrap;
            out_poly  <= poly_cnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_power2round_pack_stream.sv
// Self-checking bench for power2round_pack_stream: directed steps plus a
// scoreboard filled on input acceptance and drained on output handshakes.
module tb_power2round_pack_stream;

    logic        clk = 1'b0;
    logic        reset, zeroize, start, in_valid, in_ready, out_valid, out_ready;
    logic [95:0] in_data;
    logic [39:0] t1_data;
    logic [51:0] t0_data;
    logic        out_last, busy, done;
    logic [2:0]  out_poly;

    always #5 clk = ~clk;

    power2round_pack_stream #(.COEFF_PER_BEAT(4), .NUM_POLY(8)) dut (
        .clk(clk), .reset(reset), .zeroize(zeroize), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .t1_data(t1_data), .t0_data(t0_data),
        .out_last(out_last), .out_poly(out_poly),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic [39:0] t1;
        logic [51:0] t0;
        logic        last;
        logic [2:0]  poly;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0, failures = 0, done_cnt = 0;
    int   exp_beat = 0, exp_poly = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference split using the centred-remainder definition of power2round.
    function automatic exp_t model(input logic [95:0] d, input logic last, input logic [2:0] poly);
        exp_t e;
        e.last = last;
        e.poly = poly;
        for (int i = 0; i < 4; i++) begin
            int r, r0, r1, t0v;
            r  = int'(d[24*i +: 23]);
            r0 = r % 8192;
            if (r0 > 4096) r0 = r0 - 8192;
            r1  = (r - r0) / 8192;
            t0v = 4096 - r0;
            e.t1[10*i +: 10] = r1[9:0];
            e.t0[13*i +: 13] = t0v[12:0];
        end
        return e;
    endfunction

    // Monitor sits on the falling edge; everything it sees is what the next
    // rising edge will act on.
    always @(negedge clk) begin
        if (reset || zeroize) begin
            sb.delete();
            exp_beat = 0;
            exp_poly = 0;
        end else begin
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("unexpected_beat", 1, 0);
                else begin
                    mon_e = sb.pop_front();
                    check("beat", {t1_data, t0_data, out_last, out_poly}, mon_e);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_data, exp_beat == 63, 3'(exp_poly)));
                exp_beat++;
                if (exp_beat == 64) begin
                    exp_beat = 0;
                    exp_poly = (exp_poly + 1) % 8;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data(output logic [95:0] d);
        for (int i = 0; i < 4; i++)
            d[24*i +: 24] = {1'($urandom), 23'($urandom_range(0, 8380416))};
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Offer beats with the given valid/ready percentages until n are accepted.
    task automatic feed(input int n, input int vp, input int rp);
        int got = 0, cyc = 0;
        logic [95:0] d;
        while (got < n && cyc < n * 20 + 100) begin
            rand_data(d);
            in_data   = d;
            in_valid  = ($urandom_range(0, 99) < vp);
            out_ready = ($urandom_range(0, 99) < rp);
            #1;
            if (in_valid && in_ready) got++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check("feed_accepts", got, n);
    endtask

    task automatic wait_done(input int rp);
        bit seen = 0;
        int cyc = 0;
        while (!seen && cyc < 200) begin
            out_ready = ($urandom_range(0, 99) < rp);
            #1;
            if (done) seen = 1;
            step();
            cyc++;
        end
        check("done_seen", seen, 1);
        check("idle_after_done", busy, 0);
    endtask

    task automatic run_random(input int vp, input int rp);
        do_start();
        feed(512, vp, rp);
        wait_done(rp);
    endtask

    initial begin
        logic [95:0] d;
        logic [39:0] t1_snap;
        logic [51:0] t0_snap;
        int          stalls, d0;

        reset = 1'b1; zeroize = 1'b0; start = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) step();
        check("rst_out_valid", out_valid, 0);
        check("rst_t1", t1_data, 0);
        check("rst_t0", t0_data, 0);
        check("rst_last", out_last, 0);
        check("rst_poly", out_poly, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        step();

        // Full run at full throughput, boundary beat first, stray start at beat 10.
        out_ready = 1'b1;
        do_start();
        check("busy_run", busy, 1);
        in_valid = 1'b1;
        in_data  = {24'd8380416, 24'd4097, 24'd4096, 24'd0};
        step();
        check("bnd_valid", out_valid, 1);
        check("bnd_t1", t1_data, {10'd1023, 10'd1, 10'd0, 10'd0});
        check("bnd_t0", t0_data, {13'd4096, 13'd8191, 13'd0, 13'd4096});
        stalls = 0;
        for (int b = 1; b < 512; b++) begin
            rand_data(d);
            in_data = d;
            start   = (b == 10);
            #1;
            if (!in_ready) stalls++;
            step();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check("full_stalls", stalls, 0);
        check("flush_valid", out_valid, 1);
        check("flush_last", out_last, 1);
        check("flush_poly", out_poly, 7);
        check("flush_busy", busy, 1);
        check("flush_no_done", done, 0);
        step();
        check("done_pulse", done, 1);
        check("done_out_valid", out_valid, 0);
        step();
        check("done_cleared", done, 0);
        check("idle_busy", busy, 0);
        check("done_count_1", done_cnt, 1);

        // Backpressure: five cycles with out_ready low mid-polynomial.
        do_start();
        feed(20, 100, 100);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        t1_snap   = t1_data;
        t0_snap   = t0_data;
        check("bp_valid", out_valid, 1);
        for (int c = 0; c < 5; c++) begin
            rand_data(d);
            in_data = d;
            #1;
            check("bp_in_ready", in_ready, 0);
            step();
            check("bp_t1_hold", t1_data, t1_snap);
            check("bp_t0_hold", t0_data, t0_snap);
        end
        feed(492, 70, 70);
        wait_done(70);

        // Random traffic, 4 more runs.
        run_random(70, 70);
        run_random(50, 90);
        run_random(90, 50);
        run_random(100, 30);
        check("done_count_6", done_cnt, 6);

        // Reset mid-run, then zeroize mid-run, then a clean run.
        d0 = done_cnt;
        do_start();
        feed(100, 100, 100);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_t1", t1_data, 0);
        check("mid_rst_t0", t0_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        step();
        reset = 1'b0;
        step();
        do_start();
        feed(30, 100, 100);
        zeroize = 1'b1;
        step();
        zeroize = 1'b0;
        check("zz_valid", out_valid, 0);
        check("zz_t1", t1_data, 0);
        check("zz_t0", t0_data, 0);
        check("zz_last_poly", {out_last, out_poly}, 0);
        check("zz_busy", busy, 0);
        repeat (5) step();
        check("no_done_after_abort", done_cnt, d0);
        run_random(80, 80);
        check("done_after_restart", done_cnt, d0 + 1);
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
